moore_seq_det: RTL and testbench

Parametrised Moore sequence detector, the successor to the fixed 2-bit `moore_fsm`. It recognises a configurable serial bit pattern on input `I`, with selectable overlapping or non-overlapping matching and an optional saturating hit counter. It sits in the same control-path role: serial qualifier in, registered state and a Moore flag out.

---
 rtl/moore_seq_det.sv | 138 +++++++++++++
 tb/tb_moore_seq_det.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_det.sv
// moore_seq_det: parametrised Moore sequence detector.
//
// Recognises the serial pattern PATTERN (PATTERN[PAT_W-1] received first) on I.
// The state register holds the length of the longest pattern prefix that is a
// suffix of the consumed bits (0..PAT_W). Transitions follow the KMP step, which
// is computed at elaboration from the constant pattern, so no input history
// register is kept. OVERLAP selects whether a completed match may seed the next.
//
// Optional feature macro: MOORE_SEQ_DET_HITCNT_EN
//   defined     - saturating hit counter with synchronous CLR and CNT_SAT flag.
//   not defined - HIT_CNT and CNT_SAT tied to 0, CLR ignored.
//
// Ports:
//   CLK      in   clock, rising edge
//   RST      in   asynchronous active-high reset
//   EN       in   sample enable, I consumed only when EN=1
//   I        in   serial data bit
//   CLR      in   synchronous hit-counter clear (priority over increment)
//   Q        out  current state = matched prefix length
//   Y        out  Moore detect flag, (Q == PAT_W)
//   HIT_CNT  out  saturating count of detections
//   CNT_SAT  out  high while HIT_CNT is all ones

module moore_seq_det #(
    parameter int unsigned        PAT_W   = 4,
    parameter logic [PAT_W-1:0]   PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int unsigned        CNT_W   = 8,
    parameter int unsigned        STATE_W = $clog2(PAT_W + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               I,
    input  logic               CLR,
    output logic [STATE_W-1:0] Q,
    output logic               Y,
    output logic [CNT_W-1:0]   HIT_CNT,
    output logic               CNT_SAT
);

    localparam logic [STATE_W-1:0] FULL = STATE_W'(PAT_W);

    // Pattern bit in reception order: idx 0 is the first bit received.
    function automatic logic pat_bit(input int unsigned idx);
        logic [PAT_W-1:0] sh;
        sh = PATTERN >> (PAT_W - 1 - idx);
        return sh[0];
    endfunction

    // Longest j such that the first j pattern bits equal the last j bits of
    // (first k pattern bits, then b). From the full state without overlap the
    // machine restarts as if from state 0.
    function automatic logic [STATE_W-1:0] kmp_next(input int unsigned k, input logic b);
        int unsigned base;
        int unsigned best;
        int unsigned m;
        logic        ok;
        logic        sb;
        base = (k == PAT_W && !OVERLAP) ? 32'd0 : k;
        best = 0;
        for (int unsigned j = 1; j <= PAT_W; j++) begin
            if (j <= base + 1) begin
                ok = 1'b1;
                for (int unsigned n = 0; n < PAT_W; n++) begin
                    if (n < j) begin
                        m  = base + 1 - j + n;
                        sb = (m < base) ? pat_bit(m) : b;
                        if (sb != pat_bit(n)) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return STATE_W'(best);
    endfunction

    // Transition table, constant after elaboration.
    logic [STATE_W-1:0] nxt_on0 [PAT_W+1];
    logic [STATE_W-1:0] nxt_on1 [PAT_W+1];

    for (genvar k = 0; k <= PAT_W; k++) begin : g_next
        assign nxt_on0[k] = kmp_next(k, 1'b0);
        assign nxt_on1[k] = kmp_next(k, 1'b1);
    end

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_nxt;

    always_comb begin
        state_nxt = I ? nxt_on1[state_q] : nxt_on0[state_q];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= '0;
        end else if (EN) begin
            state_q <= state_nxt;
        end
    end

    assign Q = state_q;
    // Decoded from the state register only; never combinational on I or EN.
    assign Y = (state_q == FULL);

`ifdef MOORE_SEQ_DET_HITCNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             hit;
    logic             cnt_full;

    assign hit      = EN && (state_nxt == FULL);
    assign cnt_full = (cnt_q == {CNT_W{1'b1}});

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (CLR) begin
            cnt_q <= '0;
        end else if (hit && !cnt_full) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign HIT_CNT = cnt_q;
    assign CNT_SAT = cnt_full;
`else
    logic unused_clr;

    assign unused_clr = CLR;
    assign HIT_CNT    = '0;
    assign CNT_SAT    = 1'b0;
`endif

endmodule

// File: tb/tb_moore_seq_det.sv
// Directed bench for moore_seq_det. Three instances share stimulus:
//   a: defaults (overlap, 8-bit counter)
//   b: non-overlapping
//   c: overlapping, 2-bit counter (saturation)
// A history-based model (longest pattern-prefix suffix of consumed bits) is
// compared against every instance each cycle; literal checks pin the model.

module tb_moore_seq_det;

    localparam int         PW  = 4;
    localparam logic [3:0] PAT = 4'b1011;
`ifdef MOORE_SEQ_DET_HITCNT_EN
    localparam int HC_ON = 1;
`else
    localparam int HC_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst, en, din, clr;

    logic [2:0] q_a, q_b, q_c;
    logic       y_a, y_b, y_c;
    logic [7:0] hc_a, hc_b;
    logic [1:0] hc_c;
    logic       sat_a, sat_b, sat_c;

    moore_seq_det #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .CLK(clk), .RST(rst), .EN(en), .I(din), .CLR(clr),
        .Q(q_a), .Y(y_a), .HIT_CNT(hc_a), .CNT_SAT(sat_a)
    );
    moore_seq_det #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .CLK(clk), .RST(rst), .EN(en), .I(din), .CLR(clr),
        .Q(q_b), .Y(y_b), .HIT_CNT(hc_b), .CNT_SAT(sat_b)
    );
    moore_seq_det #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
        .CLK(clk), .RST(rst), .EN(en), .I(din), .CLR(clr),
        .Q(q_c), .Y(y_c), .HIT_CNT(hc_c), .CNT_SAT(sat_c)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: consumed-bit history (newest in bit 0), state, hit count.
    bit          m_ovl [3] = '{1'b1, 1'b0, 1'b1};
    int          m_max [3] = '{255, 255, 3};
    logic [31:0] m_hist [3];
    int          m_hlen [3];
    int          m_q [3];
    int          m_cnt [3];

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_hist[d] = '0;
            m_hlen[d] = 0;
            m_q[d]    = 0;
            m_cnt[d]  = 0;
        end
    endtask

    function automatic int longest(input int d);
        int          best;
        logic [3:0]  pt;
        logic [31:0] ht;
        logic        ok;
        best = 0;
        for (int k = 1; k <= PW; k++) begin
            if (k <= m_hlen[d]) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    pt = PAT >> (PW - 1 - j);
                    ht = m_hist[d] >> (k - 1 - j);
                    if (pt[0] != ht[0]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    task automatic model_step(input int d, input logic e, input logic b, input logic c);
        if (e) begin
            // Without overlap a completed match leaves nothing to build on.
            if (!m_ovl[d] && m_q[d] == PW) begin
                m_hist[d] = '0;
                m_hlen[d] = 0;
            end
            m_hist[d] = {m_hist[d][30:0], b};
            if (m_hlen[d] < 32) m_hlen[d]++;
            m_q[d] = longest(d);
            if (m_q[d] == PW && m_cnt[d] < m_max[d]) m_cnt[d]++;
        end
        if (c) m_cnt[d] = 0;
    endtask

    task automatic cmp_dut(input int d, input int q, input int y, input int cnt, input int sat);
        int ec;
        int es;
        ec = HC_ON ? m_cnt[d] : 0;
        es = (HC_ON != 0 && m_cnt[d] == m_max[d]) ? 1 : 0;
        chk($sformatf("dut%0d_q", d), q, m_q[d]);
        chk($sformatf("dut%0d_y", d), y, (m_q[d] == PW) ? 1 : 0);
        chk($sformatf("dut%0d_hit_cnt", d), cnt, ec);
        chk($sformatf("dut%0d_cnt_sat", d), sat, es);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            cmp_dut(0, int'(q_a), int'(y_a), int'(hc_a), int'(sat_a));
            cmp_dut(1, int'(q_b), int'(y_b), int'(hc_b), int'(sat_b));
            cmp_dut(2, int'(q_c), int'(y_c), int'(hc_c), int'(sat_c));
        end
    end

    // Drive at negedge, advance model at the edge, return 1 time unit after it.
    task automatic step(input logic e, input logic b, input logic c);
        @(negedge clk);
        en  = e;
        din = b;
        clr = c;
        @(posedge clk);
        for (int d = 0; d < 3; d++) model_step(d, e, b, c);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    int basic_bits [5] = '{1, 0, 1, 1, 0};
    int basic_q [5]    = '{1, 2, 3, 4, 2};
    int basic_y [5]    = '{0, 0, 0, 1, 0};
    int ovl_bits [7]   = '{1, 0, 1, 1, 0, 1, 1};
    int seq4 [4]       = '{1, 0, 1, 1};

    initial begin
        int pulses_a;
        int pulses_b;
        rst = 1'b1;
        en  = 1'b0;
        din = 1'b0;
        clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("reset_q", int'(q_a), 0);
        chk("reset_y", int'(y_a), 0);
        chk("reset_hit_cnt", int'(hc_a), 0);
        chk("reset_cnt_sat", int'(sat_a), 0);
        rst = 1'b0;
        cmp_on = 1'b1;

        // Basic match.
        for (int k = 0; k < 5; k++) begin
            step(1'b1, basic_bits[k][0], 1'b0);
            chk("basic_q", int'(q_a), basic_q[k]);
            chk("basic_y", int'(y_a), basic_y[k]);
        end
        chk("basic_hit_cnt", int'(hc_a), HC_ON ? 1 : 0);

        // Overlap vs non-overlap.
        apply_reset();
        pulses_a = 0;
        pulses_b = 0;
        for (int k = 0; k < 7; k++) begin
            step(1'b1, ovl_bits[k][0], 1'b0);
            if (y_a) pulses_a++;
            if (y_b) pulses_b++;
            if (k == 4) chk("novl_q_after_5th", int'(q_b), 0);
        end
        chk("ovl_q_end", int'(q_a), 4);
        chk("ovl_pulses", pulses_a, 2);
        chk("novl_pulses", pulses_b, 1);
        chk("ovl_hit_cnt", int'(hc_a), HC_ON ? 2 : 0);
        chk("novl_hit_cnt", int'(hc_b), HC_ON ? 1 : 0);

        // Enable gating.
        apply_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, k[0], 1'b0);
            chk("en_hold_q", int'(q_a), 2);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("en_resume_q", int'(q_a), 4);
        chk("en_resume_y", int'(y_a), 1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("en_hold_y", int'(y_a), 1);
        chk("en_hold_hit_cnt", int'(hc_a), HC_ON ? 1 : 0);

        // Asynchronous reset while in S3.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("pre_reset_q", int'(q_a), 3);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_reset_q", int'(q_a), 0);
        chk("async_reset_y", int'(y_a), 0);
        chk("async_reset_hit_cnt", int'(hc_a), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        chk("post_reset_q", int'(q_a), 1);

        // Saturation and clear on the instance with a 2-bit counter.
        apply_reset();
        for (int h = 0; h < 4; h++) begin
            for (int k = 0; k < 4; k++) step(1'b1, seq4[k][0], 1'b0);
        end
        chk("sat_hit_cnt", int'(hc_c), HC_ON ? 3 : 0);
        chk("sat_flag", int'(sat_c), HC_ON ? 1 : 0);
        chk("sat_wide_hit_cnt", int'(hc_a), HC_ON ? 4 : 0);
        for (int k = 0; k < 3; k++) step(1'b1, seq4[k][0], 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_hit_cnt", int'(hc_c), 0);
        chk("clr_flag", int'(sat_c), 0);
        chk("clr_y", int'(y_c), 1);

        // Clear with EN low leaves the state alone.
        for (int k = 0; k < 4; k++) step(1'b1, seq4[k][0], 1'b0);
        chk("pre_clr_hit_cnt", int'(hc_c), HC_ON ? 1 : 0);
        step(1'b0, 1'b1, 1'b1);
        chk("clr_en0_hit_cnt", int'(hc_c), 0);
        chk("clr_en0_q", int'(q_c), 4);
        step(1'b0, 1'b0, 1'b0);

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
